seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width, integer >= 4.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH): shift-amount bits taken from in_b.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-007 in_op  input  4  opcode: AND 0000, OR 0001, ADD 0010, SLL 0011, DIVU 0100, BNE 0101, SUB 0110, SLT 0111.
REQ-008 in_a, in_b  input  WIDTH  operands (in_b is divisor or shift amount where applicable).
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_result  output  WIDTH  primary result (quotient for DIVU).
REQ-012 out_rem  output  WIDTH  DIVU remainder; 0 for all other ops.
REQ-013 out_zero, out_carry, out_ovf, out_dbz  output  1 each  result==0; adder carry-out; signed overflow (ADD/SUB only); divide-by-zero.

Function
REQ-014 SHALL accept a request when in_valid && in_ready, capturing in_op, in_a and in_b.
REQ-015 FSM SHALL have states IDLE, DIV and DONE; reset state IDLE.
REQ-016 IDLE: on accept of a non-DIVU op -> DONE, with the result registered at that edge (out_valid one cycle after accept).
REQ-017 IDLE: on accept of DIVU with in_b != 0 -> DIV; with in_b == 0 -> DONE, out_result all ones, out_rem = in_a, out_dbz=1.
REQ-018 DIV SHALL run restoring unsigned division, one quotient bit per cycle, MSB first, using a WIDTH-bit iteration counter; after exactly WIDTH cycles in DIV -> DONE (out_valid WIDTH+1 cycles after accept).
REQ-019 DONE: out_valid=1 and all outputs held stable until out_valid && out_ready, then -> IDLE; the next request is accepted no earlier than the following cycle.
REQ-020 ADD/SUB SHALL compute in_a + in_b and in_a + ~in_b + 1 in a WIDTH+1-bit adder, out_carry = bit WIDTH.
REQ-021 out_ovf SHALL be set when both operands have the same sign and the result sign differs, using the effective (inverted for SUB) B operand; out_ovf=0 for all other ops.
REQ-022 SLT SHALL give out_result = {WIDTH-1 zeros, (A-B sign) XOR ovf}, i.e. signed compare.
REQ-023 BNE SHALL give out_result = A-B; the branch is taken when out_zero==0.
REQ-024 SLL SHALL give out_result = in_a << in_b[SHW-1:0]; upper in_b bits ignored.
REQ-025 AND/OR SHALL be bitwise; carry and ovf = 0.
REQ-026 Undefined opcodes SHALL complete like a non-DIVU op with all result and flag outputs 0.
REQ-027 out_zero SHALL reflect out_result only (not out_rem).
REQ-028 in_valid asserted while not in IDLE SHALL be ignored, with no side effects.

Reset
REQ-029 rst_n low SHALL force IDLE immediately, and out_valid, out_result, out_rem and all flags to 0; the iteration counter and working registers SHALL clear.
REQ-030 Reset asserted during DIV or DONE SHALL abort the operation with no result delivered; in_ready=1 on the first edge after rst_n is released.

Structure
REQ-031 Opcode constants SHALL live in the shared package alu_pkg, reused by the pipeline control decoder.
REQ-032 FSM state encoding SHALL be a typedef in alu_pkg.
REQ-033 Division datapath SHALL be one sub-module, divu_iter (one shift/subtract step per enable, ready after WIDTH steps).

Verification
REQ-034 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf=1, carry=0, out_valid the cycle after accept.
REQ-035 SUB 5 - 5 (BNE op) -> result 0, zero=1, carry=1; SLT 0xFFFFFFFF vs 1 -> result 1.
REQ-036 DIVU 100 / 7 -> quotient 14, rem 2, out_valid exactly 33 cycles after accept (WIDTH=32).
REQ-037 DIVU 9 / 0 -> result 0xFFFFFFFF, rem 9, dbz=1, out_valid the cycle after accept.
REQ-038 out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout; a new in_valid pulse during that time is ignored.
REQ-039 rst_n pulsed low mid-DIV (cycle 10) -> out_valid=0 and in_ready=1 after release; a following SLL 1 << 33 (SHW=5) -> result 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding (also used by the pipeline control
// decoder) and the sequential-ALU FSM state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_DIVU = 4'b0100,
    OP_BNE  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Ops that run the adder as A + ~B + 1
  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_BNE) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_rem;
  logic             out_zero;
  logic             out_carry;
  logic             out_ovf;
  logic             out_dbz;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_rem,
           out_zero, out_carry, out_ovf, out_dbz
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_rem,
           out_zero, out_carry, out_ovf, out_dbz
  );
endinterface

// File: rtl/divu_iter.sv
// Restoring unsigned divider, one quotient bit per enabled cycle, MSB first.
// The step outputs are the values the registers take on the current step, so
// the caller can capture the final quotient/remainder on the last step edge.
module divu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] q_step_o,
  output logic [WIDTH-1:0] r_step_o,
  output logic             last_o
);

  localparam logic [WIDTH-1:0] STEPS = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, r_q, d_q, cnt_q;
  logic [WIDTH:0]   r_sh, diff;
  logic             ge;

  // Shift next dividend bit into the partial remainder, trial-subtract
  assign r_sh     = {r_q, q_q[WIDTH-1]};
  assign diff     = r_sh - {1'b0, d_q};
  assign ge       = ~diff[WIDTH];
  assign r_step_o = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign q_step_o = {q_q[WIDTH-2:0], ge};
  assign last_o   = (cnt_q == LAST);

  // Working registers: load on start, one step per enable until WIDTH steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      q_q   <= dividend_i;
      r_q   <= '0;
      d_q   <= divisor_i;
      cnt_q <= '0;
    end else if (en_i && cnt_q != STEPS) begin
      q_q   <= q_step_o;
      r_q   <= r_step_o;
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, multi-cycle unsigned divide.
// Results are held in DONE until the consumer takes them.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, rem_q;
  logic             zero_q, carry_q, ovf_q, dbz_q;

  logic             sub_op, add_ovf, known_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c, rem_c;
  logic             carry_c, ovf_c, dbz_c, zero_c;
  logic             div_start, div_en, div_last, load_alu, load_div;
  logic [WIDTH-1:0] q_step, r_step;

  // Shared WIDTH+1 adder; subtract-class ops invert B and inject carry
  assign sub_op   = is_sub_op(bus.in_op);
  assign b_eff    = sub_op ? ~bus.in_b : bus.in_b;
  assign sum      = {1'b0, bus.in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
  assign add_ovf  = (bus.in_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
  assign known_op = ~bus.in_op[3];

  // Single-cycle result for the op being accepted (DIVU only for b == 0)
  always_comb begin
    res_c   = '0;
    rem_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    dbz_c   = 1'b0;
    case (bus.in_op)
      OP_AND:  res_c = bus.in_a & bus.in_b;
      OP_OR:   res_c = bus.in_a | bus.in_b;
      OP_ADD,
      OP_SUB:  begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = add_ovf;
      end
      OP_BNE:  begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
      end
      OP_SLT:  begin
        res_c   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        carry_c = sum[WIDTH];
      end
      OP_SLL:  res_c = bus.in_a << bus.in_b[SHW-1:0];
      OP_DIVU: begin
        res_c = '1;
        rem_c = bus.in_a;
        dbz_c = 1'b1;
      end
      default: ;
    endcase
    zero_c = known_op && (res_c == '0);
  end

  divu_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .en_i       (div_en),
    .dividend_i (bus.in_a),
    .divisor_i  (bus.in_b),
    .q_step_o   (q_step),
    .r_step_o   (r_step),
    .last_o     (div_last)
  );

  // FSM next state and datapath controls
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    div_en    = 1'b0;
    load_alu  = 1'b0;
    load_div  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        if (bus.in_op == OP_DIVU && bus.in_b != '0) begin
          state_d   = ST_DIV;
          div_start = 1'b1;
        end else begin
          state_d  = ST_DONE;
          load_alu = 1'b1;
        end
      end
      ST_DIV: begin
        div_en = 1'b1;
        if (div_last) begin
          state_d  = ST_DONE;
          load_div = 1'b1;
        end
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Result/flag registers, held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (load_alu) begin
      res_q   <= res_c;
      rem_q   <= rem_c;
      zero_q  <= zero_c;
      carry_q <= carry_c;
      ovf_q   <= ovf_c;
      dbz_q   <= dbz_c;
    end else if (load_div) begin
      res_q   <= q_step;
      rem_q   <= r_step;
      zero_q  <= (q_step == '0);
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_result = res_q;
  assign bus.out_rem    = rem_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_dbz    = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized + directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic [3:0]  fl;   // {zero, carry, ovf, dbz}
    int          lat;
  } exp_t;

  // Reference model from the op definitions, using wide/signed arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, s;
    logic [32:0] w;
    logic z, c, o, d;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = 32'd0; e.rem = 32'd0; e.lat = 1;
    z = 1'b0; c = 1'b0; o = 1'b0; d = 1'b0;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin
        w = {1'b0, a} + {1'b0, b};
        e.res = w[31:0]; c = w[32];
        s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: e.res = a << b[4:0];
      4'd4: begin
        if (b == 32'd0) begin
          e.res = 32'hFFFF_FFFF; e.rem = a; d = 1'b1;
        end else begin
          e.res = a / b; e.rem = a % b; e.lat = 33;
        end
      end
      4'd5: begin e.res = a - b; c = (a >= b); end
      4'd6: begin
        e.res = a - b; c = (a >= b);
        s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: begin e.res = (sa < sb) ? 32'd1 : 32'd0; c = (a >= b); end
      default: ;
    endcase
    if (op < 4'd8) z = (e.res == 32'd0);
    e.fl = {z, c, o, d};
    return e;
  endfunction

  // Issue one request from IDLE, wait (bounded) for the result, then consume it
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [31:0] rm, output logic [3:0] fl,
                        output int lat, output bit to);
    bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !bus.out_valid;
    r  = bus.out_result;
    rm = bus.out_rem;
    fl = {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_dbz};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = 4'd0; bus.in_a = 32'd0; bus.in_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL reset_hs: got rdy/vld %b want 10", {bus.in_ready, bus.out_valid});
    end
    n_cmp++;
    if ({bus.out_result, bus.out_rem} !== 64'd0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h want 0/0", bus.out_result, bus.out_rem);
    end
    n_cmp++;
    if ({bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_dbz} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000",
                        {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_dbz});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] r, rm; logic [3:0] fl; int lat; bit to;
    run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, r, rm, fl, lat, to);
    n_cmp++;
    if (to || r !== 32'h8000_0000 || fl !== 4'b0010 || lat !== 1) begin
      n_bad++; $display("FAIL dir_add_ovf: got r=%h fl=%b lat=%0d want 80000000 0010 1", r, fl, lat);
    end
    run_op(4'd5, 32'd5, 32'd5, r, rm, fl, lat, to);
    n_cmp++;
    if (to || r !== 32'd0 || fl !== 4'b1100) begin
      n_bad++; $display("FAIL dir_bne_eq: got r=%h fl=%b want 0 1100", r, fl);
    end
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, r, rm, fl, lat, to);
    n_cmp++;
    if (to || r !== 32'd1) begin
      n_bad++; $display("FAIL dir_slt: got %h want 1", r);
    end
    run_op(4'd4, 32'd100, 32'd7, r, rm, fl, lat, to);
    n_cmp++;
    if (to || r !== 32'd14 || rm !== 32'd2 || lat !== 33) begin
      n_bad++; $display("FAIL dir_divu: got q=%0d r=%0d lat=%0d want 14 2 33", r, rm, lat);
    end
    run_op(4'd4, 32'd9, 32'd0, r, rm, fl, lat, to);
    n_cmp++;
    if (to || r !== 32'hFFFF_FFFF || rm !== 32'd9 || fl[0] !== 1'b1 || lat !== 1) begin
      n_bad++; $display("FAIL dir_dbz: got r=%h rem=%0d fl=%b lat=%0d want ffffffff 9 xxx1 1", r, rm, fl, lat);
    end
    run_op(4'd9, 32'h1234_5678, 32'h0, r, rm, fl, lat, to);
    n_cmp++;
    if (to || r !== 32'd0 || rm !== 32'd0 || fl !== 4'b0000 || lat !== 1) begin
      n_bad++; $display("FAIL dir_undef: got r=%h rem=%h fl=%b lat=%0d want 0 0 0000 1", r, rm, fl, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, rm; logic [3:0] op, fl; int lat; bit to; exp_t e;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if (i % 3 == 0) op = 4'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b = a;
      e = model(op, a, b);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL rand_idle: got in_ready %b want 1", bus.in_ready);
      end
      run_op(op, a, b, r, rm, fl, lat, to);
      n_cmp++;
      if (to) begin
        n_bad++; $display("FAIL rand_timeout op=%0d: got no out_valid want out_valid", op);
      end
      n_cmp++;
      if (r !== e.res) begin
        n_bad++; $display("FAIL rand_res op=%0d a=%h b=%h: got %h want %h", op, a, b, r, e.res);
      end
      n_cmp++;
      if (rm !== e.rem) begin
        n_bad++; $display("FAIL rand_rem op=%0d a=%h b=%h: got %h want %h", op, a, b, rm, e.rem);
      end
      n_cmp++;
      if (fl !== e.fl) begin
        n_bad++; $display("FAIL rand_flags op=%0d a=%h b=%h: got %b want %b", op, a, b, fl, e.fl);
      end
      n_cmp++;
      if (lat !== e.lat) begin
        n_bad++; $display("FAIL rand_lat op=%0d: got %0d want %0d", op, lat, e.lat);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e; int k;
    e = model(4'd6, 32'd3, 32'd10);
    bus.in_op = 4'd6; bus.in_a = 32'd3; bus.in_b = 32'd10; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 50) begin @(posedge clk); #1; k++; end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.in_op = 4'd4; bus.in_a = 32'd77; bus.in_b = 32'd5; bus.in_valid = 1'b1;
      end
      if (c == 2) bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_result !== e.res ||
          {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_dbz} !== e.fl) begin
        n_bad++; $display("FAIL hold_c%0d: got vld=%b rdy=%b r=%h want 1 0 %h",
                          c, bus.out_valid, bus.in_ready, bus.out_result, e.res);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL hold_release: got vld/rdy %b want 01", {bus.out_valid, bus.in_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL hold_ignored: got vld/rdy %b want 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] r, rm; logic [3:0] fl; int lat, seen; bit to;
    bus.in_op = 4'd4; bus.in_a = 32'd100; bus.in_b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.out_result, bus.out_rem} !== {2'b01, 64'd0}) begin
      n_bad++; $display("FAIL rst_async: got vld=%b rdy=%b r=%h want 0 1 0",
                        bus.out_valid, bus.in_ready, bus.out_result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rst_release: got vld/rdy %b want 01", {bus.out_valid, bus.in_ready});
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL rst_no_result: got %0d valid cycles want 0", seen);
    end
    run_op(4'd3, 32'd1, 32'd33, r, rm, fl, lat, to);
    n_cmp++;
    if (to || r !== 32'd2 || lat !== 1) begin
      n_bad++; $display("FAIL rst_sll: got r=%h lat=%0d want 2 1", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
